panel_dma_seq: RTL

Front-panel memory sequencer for the Altair core. It executes EXAMINE, EXAMINE NEXT, DEPOSIT and DEPOSIT NEXT by taking the bus over a HOLD/HLDA handshake and running direct memory cycles, instead of jamming opcodes into the CPU. Address and data widths are parametrised, memory completion is acknowledged with a timeout, and held NEXT buttons can auto-repeat. It sits between the panel debouncers, the CPU hold logic and the memory-map decode.

---
 rtl/panel_dma_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/panel_dma_seq.sv
// Front-panel memory sequencer: runs EXAMINE/DEPOSIT (+NEXT) as DMA cycles over HOLD/HLDA.
// Optional auto-repeat of held NEXT buttons is enabled by defining PANEL_AUTOREPEAT_EN.
module panel_dma_seq #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int ACK_TIMEOUT   = 255,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  paused,
  input  logic                  cmd_examine,
  input  logic                  cmd_examine_next,
  input  logic                  cmd_deposit,
  input  logic                  cmd_deposit_next,
  input  logic                  rpt_held,
  input  logic [ADDR_WIDTH-1:0] addr_sw,
  input  logic [DATA_WIDTH-1:0] data_sw,
  output logic                  hold_req,
  input  logic                  hlda,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] addr_led,
  output logic [DATA_WIDTH-1:0] data_led,
  output logic                  busy,
  output logic                  err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HOLD, WR, RD, REL} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic [TW-1:0]           tmo_cnt;
  logic                    is_write;
  logic                    any_cmd;
  logic                    ext_go;
  logic                    rpt_go;
  logic                    go;
  logic                    go_load;
  logic                    go_inc;
  logic                    go_write;
  logic                    tmo_hit;

  assign mem_addr = addr_reg;
  assign addr_led = addr_reg;
  assign any_cmd  = cmd_examine | cmd_examine_next | cmd_deposit | cmd_deposit_next;
  assign ext_go   = (state == IDLE) && paused && any_cmd;
  assign go       = ext_go || rpt_go;
  assign tmo_hit  = (tmo_cnt == TW'(ACK_TIMEOUT - 1));

`ifdef PANEL_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic          rpt_armed;
  logic          rpt_write;
  logic          rpt_first;
  logic [RW-1:0] rpt_cnt;
  logic          rpt_active;
  logic          rpt_due;

  assign rpt_active = rpt_held && paused && rpt_armed;
  assign rpt_due    = rpt_active &&
                      (rpt_cnt == (rpt_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1)));
  assign rpt_go     = (state == IDLE) && !any_cmd && rpt_due;
`else
  logic rpt_unused;
  localparam int RptUnusedCfg = REPEAT_DELAY + REPEAT_PERIOD;
  assign rpt_unused = rpt_held;
  assign rpt_go     = 1'b0;
`endif

  // Priority decode of the accepted command; a repeat replays the last NEXT command.
  always_comb begin
    go_load  = 1'b0;
    go_inc   = 1'b0;
    go_write = 1'b0;
    if (cmd_examine) begin
      go_load = 1'b1;
    end else if (cmd_examine_next) begin
      go_inc = 1'b1;
    end else if (cmd_deposit) begin
      go_write = 1'b1;
    end else if (cmd_deposit_next) begin
      go_inc   = 1'b1;
      go_write = 1'b1;
    end
`ifdef PANEL_AUTOREPEAT_EN
    if (rpt_go) begin
      go_inc   = 1'b1;
      go_write = rpt_write;
    end
`endif
    nxt_addr = go_load ? addr_sw : (go_inc ? addr_reg + 1'b1 : addr_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_reg  <= '0;
      mem_wdata <= '0;
      data_led  <= '0;
      tmo_cnt   <= '0;
      is_write  <= 1'b0;
      hold_req  <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
`ifdef PANEL_AUTOREPEAT_EN
      rpt_armed <= 1'b0;
      rpt_write <= 1'b0;
      rpt_first <= 1'b1;
      rpt_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            addr_reg  <= nxt_addr;
            mem_wdata <= data_sw;
            err       <= 1'b0;
            is_write  <= go_write;
            hold_req  <= 1'b1;
            busy      <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (hlda) begin
            tmo_cnt <= '0;
            if (is_write) begin
              mem_we <= 1'b1;
              state  <= WR;
            end else begin
              mem_re <= 1'b1;
              state  <= RD;
            end
          end
        end
        WR: begin
          if (mem_ack) begin
            mem_we  <= 1'b0;
            mem_re  <= 1'b1;
            tmo_cnt <= '0;
            state   <= RD;
          end else if (tmo_hit) begin
            mem_we   <= 1'b0;
            err      <= 1'b1;
            data_led <= '1;
            hold_req <= 1'b0;
            state    <= REL;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RD: begin
          if (mem_ack) begin
            mem_re   <= 1'b0;
            data_led <= mem_rdata;
            hold_req <= 1'b0;
            state    <= REL;
          end else if (tmo_hit) begin
            mem_re   <= 1'b0;
            err      <= 1'b1;
            data_led <= '1;
            hold_req <= 1'b0;
            state    <= REL;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        REL: begin
          if (!hlda) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef PANEL_AUTOREPEAT_EN
      // Counter saturates at its target while an operation is in flight, firing once IDLE.
      if (!rpt_active || ext_go) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (rpt_go) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b0;
      end else if (!rpt_due) begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
      if (ext_go) begin
        rpt_armed <= go_inc;
        rpt_write <= go_write;
      end
`endif
    end
  end

endmodule
